// File: rtl/instruction_fetch_arbiter.sv
// Round-robin arbiter sharing two combinational instruction-memory read ports among NUM_CORES fetchers.
// Optional build macro IFETCH_FIXED_PRIORITY_EN: scan always starts at core 0 (no round-robin pointer).
module instruction_fetch_arbiter #(
    parameter int unsigned NUM_CORES     = 4,
    parameter int unsigned ADDR_WIDTH_IM = 8,
    parameter int unsigned INSTR_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CORES-1:0]               req,
    input  logic [NUM_CORES*ADDR_WIDTH_IM-1:0] req_addr,
    output logic [NUM_CORES-1:0]               gnt,
    output logic [NUM_CORES-1:0]               rvalid,
    output logic [NUM_CORES*INSTR_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH_IM-1:0]           im_address_1,
    output logic [ADDR_WIDTH_IM-1:0]           im_address_2,
    input  logic [INSTR_WIDTH-1:0]             im_read_data_1,
    input  logic [INSTR_WIDTH-1:0]             im_read_data_2
);

    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     scan_idx;
    logic [PTR_W-1:0]     idx1;
    logic [PTR_W-1:0]     idx2;
    logic [PTR_W-1:0]     last_idx;
    logic [PTR_W-1:0]     nxt_ptr;
    logic                 v1;
    logic                 v2;
    logic [NUM_CORES-1:0] gnt1;
    logic [NUM_CORES-1:0] gnt2;
    logic [NUM_CORES-1:0] rvalid_q;

    // Scan from rr_ptr modulo NUM_CORES; first requester takes port 1, second takes port 2.
    always_comb begin
        gnt1     = '0;
        gnt2     = '0;
        v1       = 1'b0;
        v2       = 1'b0;
        idx1     = '0;
        idx2     = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            scan_idx = PTR_W'((32'(rr_ptr) + k) % NUM_CORES);
            if (req[scan_idx] && !reset) begin
                if (!v1) begin
                    v1             = 1'b1;
                    idx1           = scan_idx;
                    gnt1[scan_idx] = 1'b1;
                end else if (!v2) begin
                    v2             = 1'b1;
                    idx2           = scan_idx;
                    gnt2[scan_idx] = 1'b1;
                end
            end
        end
    end

    assign gnt          = gnt1 | gnt2;
    assign im_address_1 = v1 ? req_addr[32'(idx1)*ADDR_WIDTH_IM +: ADDR_WIDTH_IM] : '0;
    assign im_address_2 = v2 ? req_addr[32'(idx2)*ADDR_WIDTH_IM +: ADDR_WIDTH_IM] : '0;

    assign last_idx = v2 ? idx2 : idx1;
    assign nxt_ptr  = (last_idx == PTR_W'(NUM_CORES - 1)) ? '0 : last_idx + PTR_W'(1);

`ifdef IFETCH_FIXED_PRIORITY_EN
    assign rr_ptr = '0;
`else
    // Pointer moves just past the last granted core; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (v1) begin
            rr_ptr <= nxt_ptr;
        end
    end
`endif

    // One-cycle response: capture the data of whichever port each core was granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= '0;
            rdata    <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                rvalid_q[i] <= gnt[i];
                if (gnt1[i]) begin
                    rdata[i*INSTR_WIDTH +: INSTR_WIDTH] <= im_read_data_1;
                end else if (gnt2[i]) begin
                    rdata[i*INSTR_WIDTH +: INSTR_WIDTH] <= im_read_data_2;
                end
            end
        end
    end

    // A response pending when reset arrives is dropped rather than shown.
    assign rvalid = rvalid_q & ~{NUM_CORES{reset}};

endmodule

// File: tb/tb_instruction_fetch_arbiter.sv
// Self-checking bench for instruction_fetch_arbiter: directed vector table, corner sequences, random vs. model.
module tb_instruction_fetch_arbiter;

    localparam int NC = 4;
    localparam int AW = 8;
    localparam int IW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     req;
    logic [NC*AW-1:0]  req_addr;
    logic [NC-1:0]     gnt;
    logic [NC-1:0]     rvalid;
    logic [NC*IW-1:0]  rdata;
    logic [AW-1:0]     im_address_1;
    logic [AW-1:0]     im_address_2;
    logic [IW-1:0]     im_read_data_1;
    logic [IW-1:0]     im_read_data_2;

    instruction_fetch_arbiter #(
        .NUM_CORES(NC), .ADDR_WIDTH_IM(AW), .INSTR_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .im_address_1(im_address_1),
        .im_address_2(im_address_2), .im_read_data_1(im_read_data_1),
        .im_read_data_2(im_read_data_2)
    );

    always #5 clk = ~clk;

    assign im_read_data_1 = 32'hA000_0000 + 32'(im_address_1);
    assign im_read_data_2 = 32'hA000_0000 + 32'(im_address_2);

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_ptr = 0;
    logic [NC-1:0] m_rv = '0;
    logic [IW-1:0] m_rd [NC];
    bit          model_valid = 1'b0;
    logic [NC-1:0] e_gnt;
    logic [AW-1:0] e_a1, e_a2;
    int          grant_list[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input logic [NC*AW-1:0] ad, input int i);
        return ad[i*AW +: AW];
    endfunction

    task automatic apply(input logic r, input logic [NC-1:0] rq, input logic [NC*AW-1:0] ad);
        int start;
        @(negedge clk);
        reset    = r;
        req      = rq;
        req_addr = ad;
        #1;
`ifdef IFETCH_FIXED_PRIORITY_EN
        start = 0;
`else
        start = m_ptr;
`endif
        grant_list.delete();
        e_gnt = '0;
        if (!r) begin
            for (int k = 0; k < NC; k++) begin
                int i = (start + k) % NC;
                if (rq[i] && grant_list.size() < 2) begin
                    grant_list.push_back(i);
                    e_gnt[i] = 1'b1;
                end
            end
        end
        e_a1 = (grant_list.size() > 0) ? addr_of(ad, grant_list[0]) : '0;
        e_a2 = (grant_list.size() > 1) ? addr_of(ad, grant_list[1]) : '0;
    endtask

    task automatic check_model();
        chk("model_gnt", 64'(gnt), 64'(e_gnt));
        chk("model_im_address_1", 64'(im_address_1), 64'(e_a1));
        chk("model_im_address_2", 64'(im_address_2), 64'(e_a2));
        if (model_valid) begin
            chk("model_rvalid", 64'(rvalid), 64'(reset ? '0 : m_rv));
            for (int i = 0; i < NC; i++)
                chk($sformatf("model_rdata%0d", i), 64'(rdata[i*IW +: IW]), 64'(m_rd[i]));
        end
    endtask

    task automatic commit();
        @(posedge clk);
        if (reset) begin
            m_ptr = 0;
            m_rv  = '0;
            for (int i = 0; i < NC; i++) m_rd[i] = '0;
            model_valid = 1'b1;
        end else begin
            m_rv = e_gnt;
            foreach (grant_list[j])
                m_rd[grant_list[j]] = 32'hA000_0000 + 32'(addr_of(req_addr, grant_list[j]));
            if (grant_list.size() > 0)
                m_ptr = (grant_list[grant_list.size()-1] + 1) % NC;
        end
    endtask

    typedef struct {
        logic          rst;
        logic [NC-1:0] rq;
        logic [NC-1:0] eg;
        logic [AW-1:0] ea1;
        logic [AW-1:0] ea2;
        logic          chk_rv;
        logic [NC-1:0] erv;
    } vec_t;

    vec_t vecs[11];
    localparam logic [NC*AW-1:0] ADDRS = 32'h3F_05_21_10;

    initial begin
        logic [NC-1:0]    cur_req;
        logic [NC*AW-1:0] cur_addr;
        logic             cur_rst;

        reset = 1'b1; req = '0; req_addr = '0;
        for (int i = 0; i < NC; i++) m_rd[i] = '0;

        //              rst   req      gnt      a1     a2     chk  rvalid
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 8'h00, 8'h00, 1'b0, 4'b0000};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000};
`ifdef IFETCH_FIXED_PRIORITY_EN
        vecs[2]  = '{1'b0, 4'b1111, 4'b0011, 8'h10, 8'h21, 1'b1, 4'b0000};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0011, 8'h10, 8'h21, 1'b1, 4'b0011};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0011, 8'h10, 8'h21, 1'b1, 4'b0011};
        vecs[5]  = '{1'b0, 4'b1010, 4'b1010, 8'h21, 8'h3F, 1'b1, 4'b0011};
        vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 8'h05, 8'h00, 1'b1, 4'b1010};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 1'b1, 4'b0100};
        vecs[8]  = '{1'b0, 4'b0001, 4'b0001, 8'h10, 8'h00, 1'b1, 4'b0000};
        vecs[9]  = '{1'b0, 4'b1001, 4'b1001, 8'h10, 8'h3F, 1'b1, 4'b0001};
        vecs[10] = '{1'b0, 4'b0011, 4'b0011, 8'h10, 8'h21, 1'b1, 4'b1001};
`else
        vecs[2]  = '{1'b0, 4'b1111, 4'b0011, 8'h10, 8'h21, 1'b1, 4'b0000};
        vecs[3]  = '{1'b0, 4'b1111, 4'b1100, 8'h05, 8'h3F, 1'b1, 4'b0011};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0011, 8'h10, 8'h21, 1'b1, 4'b1100};
        vecs[5]  = '{1'b0, 4'b1010, 4'b1010, 8'h3F, 8'h21, 1'b1, 4'b0011};
        vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 8'h05, 8'h00, 1'b1, 4'b1010};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 1'b1, 4'b0100};
        vecs[8]  = '{1'b0, 4'b0001, 4'b0001, 8'h10, 8'h00, 1'b1, 4'b0000};
        vecs[9]  = '{1'b0, 4'b1001, 4'b1001, 8'h3F, 8'h10, 1'b1, 4'b0001};
        vecs[10] = '{1'b0, 4'b0011, 4'b0011, 8'h21, 8'h10, 1'b1, 4'b1001};
`endif

        foreach (vecs[v]) begin
            apply(vecs[v].rst, vecs[v].rq, ADDRS);
            chk($sformatf("vec%0d_gnt", v), 64'(gnt), 64'(vecs[v].eg));
            chk($sformatf("vec%0d_im_address_1", v), 64'(im_address_1), 64'(vecs[v].ea1));
            chk($sformatf("vec%0d_im_address_2", v), 64'(im_address_2), 64'(vecs[v].ea2));
            if (vecs[v].chk_rv)
                chk($sformatf("vec%0d_rvalid", v), 64'(rvalid), 64'(vecs[v].erv));
            check_model();
            commit();
        end

        // Single request from core 2, then its response.
        apply(1'b0, 4'b0100, ADDRS);
        check_model();
        commit();
        apply(1'b0, 4'b0000, ADDRS);
        chk("single_rvalid", 64'(rvalid), 64'(4'b0100));
        chk("single_rdata2", 64'(rdata[2*IW +: IW]), 64'(32'hA000_0005));
        check_model();
        commit();

        // Reset arrives the cycle after a grant: response dropped, pointer back to 0.
        apply(1'b0, 4'b0010, ADDRS);
        check_model();
        commit();
        apply(1'b1, 4'b0000, ADDRS);
        chk("midreset_rvalid", 64'(rvalid), 64'(4'b0000));
        check_model();
        commit();
        apply(1'b0, 4'b1111, ADDRS);
        chk("midreset_rvalid_after", 64'(rvalid), 64'(4'b0000));
        chk("midreset_gnt_ptr0", 64'(gnt), 64'(4'b0011));
        check_model();
        commit();

        // Random traffic honouring hold-until-granted, with occasional resets.
        cur_req  = '0;
        cur_addr = '0;
        for (int c = 0; c < 400; c++) begin
            cur_rst = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < NC; i++) begin
                if (!(cur_req[i] && !e_gnt[i] && !reset)) begin
                    cur_req[i] = ($urandom_range(0, 9) < 6);
                    cur_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            apply(cur_rst, cur_req, cur_addr);
            check_model();
            commit();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_arbiter.md
# instruction_fetch_arbiter

Shares the two combinational read ports of the instruction memory among `NUM_CORES` fetch requesters using round-robin arbitration. It grants up to two requests per cycle and drives the granted addresses onto the memory ports in the same cycle. Read data returns to each core through a registered response. The block sits between the per-core fetch stages and the shared instruction ROM in the multi-core processor.

## Interface
Parameters:
- `NUM_CORES`, 4: number of requesters; must be ≥ 2.
- `ADDR_WIDTH_IM`, 8: instruction memory address width.
- `INSTR_WIDTH`, 32: instruction width.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_CORES  per-core fetch request; held until granted.
- `req_addr`  in  NUM_CORES*ADDR_WIDTH_IM  per-core address; core i uses slice [i*ADDR_WIDTH_IM +: ADDR_WIDTH_IM].
- `gnt`  out  NUM_CORES  combinational accept; the request is consumed on the edge where `req[i]` and `gnt[i]` are both 1.
- `rvalid`  out  NUM_CORES  registered, one-cycle response strobe.
- `rdata`  out  NUM_CORES*INSTR_WIDTH  registered per-core instruction; same slicing as `req_addr`.
- `im_address_1`  out  ADDR_WIDTH_IM  memory port 1 address.
- `im_address_2`  out  ADDR_WIDTH_IM  memory port 2 address.
- `im_read_data_1`  in  INSTR_WIDTH  memory port 1 data (combinational from `im_address_1`).
- `im_read_data_2`  in  INSTR_WIDTH  memory port 2 data.

## Operation
- State:
  - round-robin pointer `rr_ptr`, range 0..NUM_CORES-1;
  - registered `rvalid` and `rdata` per core.
- Arbitration each cycle:
  - Scan indices `rr_ptr`, `rr_ptr+1`, … mod NUM_CORES.
  - The first requesting index is granted on port 1; the second on port 2.
  - At most two grants per cycle.
- Address outputs:
  - A granted port carries its requester's `req_addr`.
  - An unused port is driven to 0.
- Pointer update on the clock edge:
  - One or more grants: `rr_ptr <= (last granted index + 1) mod NUM_CORES`.
  - No grants: `rr_ptr` unchanged.
- Response update on the clock edge:
  - For each granted core i: `rvalid[i] <= 1`, and `rdata[i]` takes the data of the port core i was granted.
  - For each non-granted core: `rvalid[i] <= 0`, and `rdata[i]` holds its previous value.
- Handshake:
  - A core may present a new request in the cycle immediately after a grant, giving one fetch per core per cycle at most.
  - `req_addr` must stay stable while `req` is high and ungranted.
  - There is no back-pressure on responses; a core must accept `rvalid` in the cycle it is high.
- Reset:
  - While `reset` is high, `gnt` is forced to 0 and both `im_address` outputs are 0.
  - On the reset edge: `rr_ptr <= 0`, `rvalid <= 0`, `rdata <= 0`.

## Timing
- `gnt` and `im_address_*` are combinational from `req`, `req_addr` and `rr_ptr`.
- Response latency is 1 cycle: a grant in cycle T gives `rvalid` and `rdata` valid in cycle T+1.
- Reset values: `gnt` = 0, `rvalid` = 0, `rdata` = 0, `im_address_1` = 0, `im_address_2` = 0, `rr_ptr` = 0.
- Reset asserted in cycle T+1 after a grant in T: the response is dropped and `rvalid` stays 0. The requester must re-issue.
- Pointer wrap-around: the scan is modulo NUM_CORES, so a grant on index NUM_CORES-1 sets `rr_ptr` to 0.
- `NUM_CORES` = 2: both requesting cores are granted every cycle. The pointer still updates by the same rule.
- Two cores requesting the same address both use separate ports and are both served.

## Configuration
- Macro: `IFETCH_FIXED_PRIORITY_EN`.
- Defined:
  - The scan always starts at index 0, so the lowest indices win.
  - `rr_ptr` is removed and held at a constant 0.
- Undefined (default): round-robin behaviour as described above.
- Ports and latency are identical in both builds.

## Test plan
All scenarios use NUM_CORES=4, ADDR_WIDTH_IM=8, INSTR_WIDTH=32, and a ROM model with `ROM[a] = 32'hA000_0000 + a`.
- Reset: hold `reset` for 2 cycles with all `req`=1 -> `gnt`=0 and both `im_address`=0 during reset; after reset, `rvalid`=0, `rdata`=0 and the first grants go to cores 0 and 1.
- Single request: `req`=4'b0100, core 2 address 8'h05 -> `gnt`=4'b0100 and `im_address_1`=8'h05 in the same cycle; next cycle `rvalid`=4'b0100 and core 2 `rdata`=32'hA000_0005.
- Full contention: all four cores request continuously starting from `rr_ptr`=0 -> grants 4'b0011, 4'b1100, 4'b0011 on successive cycles; each core receives `rvalid` every other cycle with the correct data.
- Wrap-around: `rr_ptr`=2, `req`=4'b1010 -> core 3 on port 1, core 1 on port 2; `rr_ptr` becomes 2.
- Reset mid-flight: grant core 0 in cycle T, assert `reset` in T+1 -> `rvalid[0]` never goes high and `rr_ptr`=0.
- With `IFETCH_FIXED_PRIORITY_EN` defined: all cores request for 3 cycles -> `gnt`=4'b0011 every cycle, and cores 2 and 3 receive no `rvalid`.
